// File: rtl/puf_pkg.sv
// Shared types and helpers for the arbiter-PUF evaluation path.
package puf_pkg;

    // Default challenge width, shared with the switch chain.
    localparam int unsigned N_STAGES_DEF = 64;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        RACE   = 2'd2,
        DONE   = 2'd3
    } state_t;

    // Bits needed to hold any value in 0..n.
    function automatic int unsigned cnt_w(input int unsigned n);
        return (n < 2) ? 32'd1 : 32'($clog2(n + 1));
    endfunction

endpackage

// File: rtl/sync2.sv
// Two-flop synchronizer bringing the asynchronous arbiter decision into clk.
module sync2 (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic meta;

    // Metastability stage followed by the stable output stage.
    always_ff @(posedge clk) begin
        if (rst) begin
            meta <= 1'b0;
            q    <= 1'b0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/puf_eval_ctrl.sv
// Arbiter-PUF evaluation controller: drives a challenge, fires N_EVAL races,
// majority-votes the synchronized arbiter decisions.
module puf_eval_ctrl
    import puf_pkg::*;
#(
    parameter int unsigned N_STAGES   = N_STAGES_DEF,
    parameter int unsigned SETTLE_CYC = 8,
    parameter int unsigned RACE_CYC   = 4,
    parameter int unsigned N_EVAL     = 15
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         chal_valid,
    output logic                         chal_ready,
    input  logic [N_STAGES-1:0]          chal_in,
    output logic [N_STAGES-1:0]          chal_out,
    output logic                         launch,
    input  logic                         arb_in,
    output logic                         resp_valid,
    input  logic                         resp_ready,
    output logic                         resp,
    output logic                         resp_stable,
    output logic [$clog2(N_EVAL+1)-1:0]  ones_cnt
);

    localparam int unsigned PHASE_MAX = (SETTLE_CYC > RACE_CYC) ? SETTLE_CYC : RACE_CYC;
    localparam int unsigned PHASE_W   = cnt_w(PHASE_MAX);
    localparam int unsigned EVAL_W    = cnt_w(N_EVAL);
    localparam int unsigned ONES_W    = $clog2(N_EVAL + 1);

    // Reject configurations that cannot produce a valid majority or sample.
    if ((N_EVAL % 2) == 0 || N_EVAL < 1) begin : g_bad_n_eval
        $error("puf_eval_ctrl: N_EVAL must be odd and >= 1");
    end
    if (RACE_CYC < 3) begin : g_bad_race_cyc
        $error("puf_eval_ctrl: RACE_CYC must be >= 3");
    end
    if (SETTLE_CYC < 1) begin : g_bad_settle_cyc
        $error("puf_eval_ctrl: SETTLE_CYC must be >= 1");
    end

    logic arb_sync;

    sync2 u_sync2 (
        .clk (clk),
        .rst (rst),
        .d   (arb_in),
        .q   (arb_sync)
    );

    state_t                state_q,  state_d;
    logic [PHASE_W-1:0]    phase_q,  phase_d;
    logic [EVAL_W-1:0]     eval_q,   eval_d;
    logic [ONES_W-1:0]     ones_d;
    logic [N_STAGES-1:0]   chal_d;
    logic                  launch_d;
    logic                  chal_ready_d;
    logic                  resp_valid_d;
    logic                  resp_d;
    logic                  stable_d;

    // State, counters and all outputs registered together.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            phase_q     <= '0;
            eval_q      <= '0;
            ones_cnt    <= '0;
            chal_out    <= '0;
            launch      <= 1'b0;
            chal_ready  <= 1'b1;
            resp_valid  <= 1'b0;
            resp        <= 1'b0;
            resp_stable <= 1'b0;
        end else begin
            state_q     <= state_d;
            phase_q     <= phase_d;
            eval_q      <= eval_d;
            ones_cnt    <= ones_d;
            chal_out    <= chal_d;
            launch      <= launch_d;
            chal_ready  <= chal_ready_d;
            resp_valid  <= resp_valid_d;
            resp        <= resp_d;
            resp_stable <= stable_d;
        end
    end

    // Next-state and next-output logic; response is voted on the final sample edge.
    always_comb begin
        state_d      = state_q;
        phase_d      = phase_q;
        eval_d       = eval_q;
        ones_d       = ones_cnt;
        chal_d       = chal_out;
        launch_d     = 1'b0;
        chal_ready_d = 1'b0;
        resp_valid_d = 1'b0;
        resp_d       = resp;
        stable_d     = resp_stable;

        case (state_q)
            IDLE: begin
                chal_ready_d = 1'b1;
                if (chal_valid && chal_ready) begin
                    chal_d       = chal_in;
                    ones_d       = '0;
                    eval_d       = '0;
                    phase_d      = '0;
                    chal_ready_d = 1'b0;
                    state_d      = SETTLE;
                end
            end

            SETTLE: begin
                if (phase_q == PHASE_W'(SETTLE_CYC - 1)) begin
                    phase_d  = '0;
                    launch_d = 1'b1;
                    state_d  = RACE;
                end else begin
                    phase_d = phase_q + PHASE_W'(1);
                end
            end

            RACE: begin
                launch_d = 1'b1;
                if (phase_q == PHASE_W'(RACE_CYC - 1)) begin
                    phase_d  = '0;
                    launch_d = 1'b0;
                    ones_d   = ones_cnt + ONES_W'(arb_sync);
                    if (eval_q == EVAL_W'(N_EVAL - 1)) begin
                        resp_valid_d = 1'b1;
                        resp_d       = (ones_d > ONES_W'(N_EVAL / 2));
                        stable_d     = (ones_d == '0) || (ones_d == ONES_W'(N_EVAL));
                        state_d      = DONE;
                    end else begin
                        eval_d  = eval_q + EVAL_W'(1);
                        state_d = SETTLE;
                    end
                end else begin
                    phase_d = phase_q + PHASE_W'(1);
                end
            end

            DONE: begin
                resp_valid_d = 1'b1;
                if (resp_valid && resp_ready) begin
                    resp_valid_d = 1'b0;
                    chal_ready_d = 1'b1;
                    state_d      = IDLE;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

endmodule

// File: doc/puf_eval_ctrl.md
# puf_eval_ctrl

Evaluation controller sitting directly downstream of the arbiter-PUF switch chain and its final arbiter latch. It accepts a challenge over a valid/ready handshake and drives the challenge bits onto the chain's select lines. It then fires N_EVAL launch pulses into the chain, samples the synchronized arbiter decision after each race, and returns a majority-voted response bit with a stability flag.

## Interface
Parameters:
- N_STAGES, 64, number of switch stages; width of the challenge.
- SETTLE_CYC, 8, cycles with launch low before each race, so the chain fully discharges; must be ≥1.
- RACE_CYC, 4, cycles launch is held high per race; must be ≥3 to cover synchronizer latency.
- N_EVAL, 15, races per challenge; must be odd and ≥1.

Ports:
- clk  in  1  single clock.
- rst  in  1  synchronous, active-high reset.
- chal_valid  in  1  challenge offered.
- chal_ready  out  1  controller can accept a challenge.
- chal_in  in  N_STAGES  challenge bits.
- chal_out  out  N_STAGES  registered select lines to chain stage C inputs.
- launch  out  1  registered race edge into both chain inputs.
- arb_in  in  1  arbiter latch output; asynchronous to clk.
- resp_valid  out  1  response available.
- resp_ready  in  1  consumer takes response.
- resp  out  1  majority-voted response.
- resp_stable  out  1  all N_EVAL races agreed.
- ones_cnt  out  $clog2(N_EVAL+1)  number of races that returned 1.

## Operation
- Reset values: chal_ready=1, chal_out=0, launch=0, resp_valid=0, resp=0, resp_stable=0, ones_cnt=0. All counters are 0 and the state is IDLE.
- IDLE: chal_ready=1 and launch=0.
  - On chal_valid&&chal_ready, latch chal_in into chal_out and clear ones_cnt and eval_cnt.
  - Then go to SETTLE.
- SETTLE: launch=0 for SETTLE_CYC cycles, then go to RACE.
- RACE: launch=1 for RACE_CYC cycles.
  - In the last RACE cycle, ones_cnt += arb_sync, where arb_sync is the second flop of the 2-flop synchronizer.
  - If eval_cnt==N_EVAL-1, go to DONE; otherwise eval_cnt++ and go to SETTLE.
- DONE: launch=0 and resp_valid=1.
  - resp = (ones_cnt > N_EVAL/2).
  - resp_stable = (ones_cnt==0 || ones_cnt==N_EVAL).
  - All response outputs hold stable until resp_ready.
  - On resp_valid&&resp_ready, go to IDLE. resp_valid drops on the next cycle.
- chal_ready=0 in SETTLE, RACE and DONE. chal_valid is ignored while chal_ready=0.
- chal_out holds the latched challenge from accept until the next accept, including through DONE and IDLE. It changes only in IDLE on an accept, and only while launch=0.
- arb_in is read only at the sample cycle. Toggles at any other time have no effect.
- Reset mid-operation: on the first edge with rst=1, all outputs return to their reset values. The partial count is discarded; no response is emitted.
- Parameter violations (even N_EVAL, RACE_CYC<3, SETTLE_CYC<1) are elaboration errors.

## Timing
- Accept happens on edge E0.
- resp_valid rises after edge E(N_EVAL*(SETTLE_CYC+RACE_CYC)). With the defaults, this is 180 cycles.
- For race k (k=0..N_EVAL-1), launch is high after edges E(k*(S+R)+S) through E(k*(S+R)+S+R-1), where S=SETTLE_CYC and R=RACE_CYC.
- The sample uses arb_in as it was registered two edges before the last RACE edge.
- Minimum challenge-to-challenge period is N_EVAL*(S+R)+2 cycles: the DONE handshake cycle plus one IDLE cycle.

## Structure
- Package puf_pkg holds:
  - the state enum (IDLE, SETTLE, RACE, DONE);
  - the default N_STAGES shared with the switch chain;
  - a cnt_w(N) width helper.
- Sub-module sync2: a 2-flop synchronizer for arb_in with synchronous reset to 0.
- Everything else is one FSM with a phase counter sized max(S,R), an eval counter, and a ones counter.

## Test plan
All scenarios use N_STAGES=8, SETTLE_CYC=4, RACE_CYC=3, N_EVAL=5, so one race period is 7 cycles.
- arb_in tied 1, challenge 8'hA5 → chal_out=8'hA5; five 3-cycle launch pulses; resp_valid after E35 with resp=1, ones_cnt=5, resp_stable=1.
- arb_in set per race to 1,0,1,0,1, stable across each sample window → ones_cnt=3, resp=1, resp_stable=0.
- Per-race pattern 0,0,1,1,0 → ones_cnt=2, resp=0, resp_stable=0. Also arb_in tied 0 → ones_cnt=0, resp=0, resp_stable=1.
- Back-pressure: resp_ready held low 10 cycles after resp_valid, with chal_valid=1 and a new challenge offered → outputs hold, chal_ready=0, chal_out unchanged. Then raise resp_ready → IDLE next cycle with chal_ready=1; the new challenge is accepted.
- rst pulsed during the 3rd RACE → next cycle launch=0, chal_out=0, chal_ready=1, resp_valid=0. A fresh challenge then completes in the full 35 cycles with a correct count.
- arb_in toggling every cycle except a stable 1 over the two edges feeding each sample → ones_cnt=5, proving the sample window is exact.
